// File: rtl/grant_burst_pkg.sv
// Shared types and helpers for the grant-driven burst controller.
package grant_burst_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } gb_state_t;

  // A zero length still moves one beat; anything past the legal maximum is cut to it.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_beats);
    if (len == 0) begin
      return 1;
    end else if (len > max_beats) begin
      return max_beats;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/grant_burst_ctrl_enc.sv
// Lowest-set-bit encoder for the arbiter grant, with a flag for multi-hot input.
module onehot_lsb_encoder #(
  parameter int AGENTS = 8,
  localparam int IDX_W = (AGENTS > 1) ? $clog2(AGENTS) : 1
) (
  input  logic [AGENTS-1:0] vec_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o,
  output logic              multi_o
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx_o = '0;
    for (int i = AGENTS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o   = |vec_i;
  assign multi_o = |(vec_i & (vec_i - AGENTS'(1)));

endmodule

// File: rtl/grant_burst_ctrl.sv
// Latches the arbiter's winner and moves its burst onto one shared valid/ready channel.
module grant_burst_ctrl
  import grant_burst_pkg::*;
#(
  parameter int AGENTS    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  localparam int LEN_W    = $clog2(MAX_BEATS + 1),
  localparam int IDX_W    = (AGENTS > 1) ? $clog2(AGENTS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [AGENTS-1:0]        agent_req,
  output logic [AGENTS-1:0]        arb_req,
  input  logic [AGENTS-1:0]        g,
  input  logic [AGENTS*LEN_W-1:0]  agent_len,
  input  logic [AGENTS*DATA_W-1:0] agent_data,
  input  logic [AGENTS-1:0]        agent_valid,
  output logic [AGENTS-1:0]        agent_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_owner,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     grant_err,
  output gb_state_t                dbg_state
);

  // Channel handshake: a beat moves on any cycle where out_valid and out_ready are both high;
  // out_valid mirrors the owner's agent_valid and the owner's agent_ready mirrors out_ready.

  gb_state_t         state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              grant_err_q, grant_err_d;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic              enc_multi;

  logic [LEN_W-1:0]  len_a  [AGENTS];
  logic [DATA_W-1:0] data_a [AGENTS];

  for (genvar i = 0; i < AGENTS; i++) begin : g_slice
    assign len_a[i]  = agent_len[i*LEN_W +: LEN_W];
    assign data_a[i] = agent_data[i*DATA_W +: DATA_W];
  end

  onehot_lsb_encoder #(.AGENTS(AGENTS)) u_enc (
    .vec_i   (g),
    .idx_o   (enc_idx),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      remaining_q <= '0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      grant_err_q <= grant_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    grant_err_d = 1'b0;
    arb_req     = '0;
    agent_ready = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    case (state_q)
      IDLE: begin
        arb_req = agent_req;
        if (enc_any) begin
          owner_d     = enc_idx;
          remaining_d = LEN_W'(clamp_len(32'(len_a[enc_idx]), MAX_BEATS));
          grant_err_d = enc_multi;
          state_d     = XFER;
        end
      end
      XFER: begin
        // Requests stay masked here, so the arbiter's stale grant is simply not looked at.
        out_valid            = agent_valid[owner_q];
        out_data             = data_a[owner_q];
        agent_ready[owner_q] = out_ready;
        out_last             = (remaining_q == LEN_W'(1));
        if (out_valid && out_ready) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_owner = owner_q;
  assign busy      = (state_q == XFER);
  assign grant_err = grant_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Bench for grant_burst_ctrl: an arbiter model in the loop, per-agent beat sources and a beat scoreboard.
module tb_grant_burst_ctrl;
  import grant_burst_pkg::*;

  localparam int AGENTS    = 8;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = 5;
  localparam int IDX_W     = 3;
  localparam int EXP_W     = IDX_W + 1 + DATA_W;

  logic                     clock;
  logic                     reset;
  logic [AGENTS-1:0]        agent_req;
  logic [AGENTS-1:0]        arb_req;
  logic [AGENTS-1:0]        g;
  logic [AGENTS*LEN_W-1:0]  agent_len;
  logic [AGENTS*DATA_W-1:0] agent_data;
  logic [AGENTS-1:0]        agent_valid;
  logic [AGENTS-1:0]        agent_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_owner;
  logic                     out_last;
  logic                     out_ready;
  logic                     busy;
  logic                     grant_err;
  gb_state_t                dbg_state;

  grant_burst_ctrl #(.AGENTS(AGENTS), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clock       (clock),
    .reset       (reset),
    .agent_req   (agent_req),
    .arb_req     (arb_req),
    .g           (g),
    .agent_len   (agent_len),
    .agent_data  (agent_data),
    .agent_valid (agent_valid),
    .agent_ready (agent_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_owner   (out_owner),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .grant_err   (grant_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered fixed-priority arbiter: grants the lowest requesting agent one cycle later.
  logic [AGENTS-1:0] arb_g_q;
  logic              arb_en;
  logic [AGENTS-1:0] g_force;
  always @(posedge clock or negedge reset) begin
    if (!reset) arb_g_q <= '0;
    else        arb_g_q <= arb_req & (~arb_req + AGENTS'(1));
  end
  assign g = arb_en ? arb_g_q : g_force;

  // ---------------- bench state ----------------
  int                n_checks = 0;
  int                n_errors = 0;
  logic [EXP_W-1:0]  exp_q[$];
  int                len_cfg [AGENTS];
  int                src_k   [AGENTS];
  logic [15:0]       salt    [AGENTS];
  logic [AGENTS-1:0] src_active, agent_req_v, drop_mask;
  int                set_tag;
  int                ready_mode;   // 0: always ready, 1: random, 2: pattern while busy
  bit                valid_all;
  int                gap_mode;     // 0: none, 1: minimum gap, 2: exact gap
  logic              rdy_pat [5];
  int                cyc, busy_cnt, xfer_cnt, prev_last_cyc;
  bit                next_is_first;
  logic              gerr_exp, gerr_cap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int a, input int k);
    return {4'(a), 4'(set_tag), 8'(k), salt[a]};
  endfunction

  function automatic int ref_beats(input int len);
    if (len == 0) return 1;
    if (len > MAX_BEATS) return MAX_BEATS;
    return len;
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    agent_req_v &= ~drop_mask;
    src_active  &= ~drop_mask;
    drop_mask    = '0;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 70);
      default: out_ready = (busy && busy_cnt < 5) ? rdy_pat[busy_cnt] : 1'b1;
    endcase
    for (int a = 0; a < AGENTS; a++) begin
      agent_valid[a] = src_active[a] && (valid_all || ($urandom_range(0, 99) < 70));
      agent_data[a*DATA_W +: DATA_W] = mk_data(a, src_k[a]);
      agent_len[a*LEN_W +: LEN_W]    = LEN_W'(len_cfg[a]);
    end
    agent_req = agent_req_v;
  endtask

  // ---------------- per-cycle monitor + scoreboard ----------------
  task automatic cycle();
    logic [EXP_W-1:0] e;
    logic [IDX_W-1:0] eo;
    @(negedge clock);
    cyc++;
    check("grant_err", 64'(grant_err), 64'(gerr_exp));
    gerr_exp = gerr_cap;
    gerr_cap = 1'b0;
    if (busy) begin
      busy_cnt++;
      check("arb_req_masked", 64'(arb_req), 64'(0));
      if (exp_q.size() != 0) begin
        e  = exp_q[0];
        eo = e[EXP_W-1 -: IDX_W];
        check("owner", 64'(out_owner), 64'(eo));
        check("out_valid", 64'(out_valid), 64'(agent_valid[eo]));
        check("agent_ready", 64'(agent_ready), out_ready ? (64'(1) << eo) : 64'(0));
        check("data_held", 64'(out_data), 64'(e[DATA_W-1:0]));
        check("last_flag", 64'(out_last), 64'(e[DATA_W]));
      end
    end else begin
      check("arb_req_idle", 64'(arb_req), 64'(agent_req));
      check("ready_idle", 64'(agent_ready), 64'(0));
      check("valid_idle", 64'(out_valid), 64'(0));
    end
    if (out_valid && out_ready) begin
      xfer_cnt++;
      check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 64'({out_owner, out_last, out_data}), 64'(e));
        if (next_is_first && prev_last_cyc >= 0) begin
          if (gap_mode == 2) check("burst_gap", 64'(cyc - prev_last_cyc), 64'(3));
          if (gap_mode == 1) check("burst_gap_min", 64'(cyc - prev_last_cyc >= 3), 64'(1));
        end
        next_is_first = 1'b0;
        if (e[DATA_W]) begin
          prev_last_cyc = cyc;
          next_is_first = 1'b1;
          drop_mask[e[EXP_W-1 -: IDX_W]] = 1'b1;
        end
      end
    end
    for (int a = 0; a < AGENTS; a++) begin
      if (agent_valid[a] && agent_ready[a]) src_k[a]++;
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  // Queue the beats every agent in mask will send, lowest index first, and raise its request.
  task automatic start_set(input logic [AGENTS-1:0] mask, input bit use_req);
    set_tag++;
    busy_cnt      = 0;
    xfer_cnt      = 0;
    prev_last_cyc = -1;
    next_is_first = 1'b1;
    for (int a = 0; a < AGENTS; a++) begin
      if (mask[a]) begin
        int n;
        salt[a]  = 16'($urandom);
        src_k[a] = 0;
        n = ref_beats(len_cfg[a]);
        for (int k = 0; k < n; k++) exp_q.push_back({IDX_W'(a), (k == n - 1), mk_data(a, k)});
      end
    end
    src_active |= mask;
    if (use_req) agent_req_v |= mask;
    drive();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (exp_q.size() == 0) break;
    end
    check("set_done", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cyc = 0; set_tag = 0; busy_cnt = 0; xfer_cnt = 0; prev_last_cyc = -1; next_is_first = 1'b1;
    gerr_exp = 1'b0; gerr_cap = 1'b0;
    ready_mode = 0; valid_all = 1'b1; gap_mode = 0;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b1; rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b1;
    src_active = '0; agent_req_v = 8'h5a; drop_mask = '0;
    arb_en = 1'b1; g_force = '0;
    for (int a = 0; a < AGENTS; a++) begin len_cfg[a] = 1; src_k[a] = 0; salt[a] = '0; end
    reset = 1'b0;
    drive();
    #12;
    check("rst_arb_req", 64'(arb_req), 64'(8'h5a));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_owner", 64'(out_owner), 64'(0));
    check("rst_grant_err", 64'(grant_err), 64'(0));
    check("rst_ready", 64'(agent_ready), 64'(0));
    agent_req_v = '0;
    drive();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single burst from agent 3.
    len_cfg[3] = 4; gap_mode = 2;
    start_set(8'h08, 1'b1);
    wait_done(40);
    check("t1_busy_cycles", 64'(busy_cnt), 64'(4));

    // Backpressure pattern while busy.
    ready_mode = 2; len_cfg[0] = 3;
    start_set(8'h01, 1'b1);
    wait_done(40);
    check("t2_xfers", 64'(xfer_cnt), 64'(3));
    check("t2_busy_cycles", 64'(busy_cnt), 64'(5));
    ready_mode = 0;

    // Contention between agents 1 and 5.
    len_cfg[1] = 2; len_cfg[5] = 3;
    start_set(8'h22, 1'b1);
    wait_done(60);
    check("t3_busy_cycles", 64'(busy_cnt), 64'(5));

    // Length edges: zero, maximum, over maximum.
    len_cfg[4] = 0;
    start_set(8'h10, 1'b1);
    wait_done(40);
    check("t4_len0_beats", 64'(xfer_cnt), 64'(1));
    len_cfg[4] = MAX_BEATS;
    start_set(8'h10, 1'b1);
    wait_done(80);
    check("t4_lenmax_beats", 64'(xfer_cnt), 64'(16));
    len_cfg[4] = 31;
    start_set(8'h10, 1'b1);
    wait_done(80);
    check("t4_clamp_beats", 64'(xfer_cnt), 64'(16));

    // Forced multi-hot grant.
    arb_en = 1'b0; gap_mode = 0; len_cfg[2] = 2;
    start_set(8'h04, 1'b0);
    g_force  = 8'b0010_0100;
    gerr_cap = 1'b1;
    cycle();
    g_force = '0;
    wait_done(40);
    check("t5_busy_cycles", 64'(busy_cnt), 64'(2));
    arb_en = 1'b1;
    repeat (2) cycle();

    // Asynchronous reset during beat 2 of 5.
    len_cfg[0] = 5;
    start_set(8'h01, 1'b1);
    for (int i = 0; i < 20 && xfer_cnt < 1; i++) cycle();
    check("t6_first_beat", 64'(xfer_cnt), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_ready", 64'(agent_ready), 64'(0));
    check("t6_rst_last", 64'(out_last), 64'(0));
    check("t6_rst_data", 64'(out_data), 64'(0));
    check("t6_rst_owner", 64'(out_owner), 64'(0));
    check("t6_rst_arb_req", 64'(arb_req), 64'(agent_req));
    exp_q.delete();
    agent_req_v = '0; src_active = '0;
    drive();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6_state_idle", 64'(dbg_state), 64'(IDLE));
    len_cfg[6] = 3;
    start_set(8'h40, 1'b1);
    wait_done(40);
    check("t6_new_burst", 64'(xfer_cnt), 64'(3));

    // Randomized request sets, lengths, valids and backpressure.
    ready_mode = 1; valid_all = 1'b0; gap_mode = 1;
    for (int it = 0; it < 20; it++) begin
      logic [AGENTS-1:0] mask;
      mask = AGENTS'($urandom_range(1, 255));
      for (int a = 0; a < AGENTS; a++) len_cfg[a] = $urandom_range(0, 31);
      start_set(mask, 1'b1);
      wait_done(3000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
